// File: rtl/data_mem_responder_if.sv
// Core-side data memory bus: core drives address/data/enables, responder
// returns registered read data plus status.
interface data_mem_responder_if;
  logic        ena;
  logic [31:0] fetch_addr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        busy;
  logic [2:0]  err;
  logic [15:0] wr_count;

  modport master (
    output ena, fetch_addr, addr, wdata, we,
    input  rdata, busy, err, wr_count
  );

  modport slave (
    input  ena, fetch_addr, addr, wdata, we,
    output rdata, busy, err, wr_count
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory for a pipelined core: self-clears after reset,
// registered write-first reads, sticky access-error flags and a write counter.
module data_mem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  data_mem_responder_if.slave bus
);
  localparam int WORDS = 1 << DEPTH_LOG2;

  typedef enum logic {CLEAR, READY} state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_clr_idx;
  logic [31:0]           r_rdata;
  logic                  r_busy;
  logic [2:0]            r_err;
  logic [15:0]           r_wr_count;
  logic [31:0]           r_faddr;
  logic                  r_faddr_vld;
  logic [31:0]           r_mem [WORDS];

  logic [31:0]           w_offset;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_aligned;
  logic                  w_in_range;
  logic                  w_ok;
  logic                  w_act;
  logic                  w_wr;

  // Offset wraps, so addresses below BASE_ADDR land far out of range.
  assign w_offset   = bus.fetch_addr - BASE_ADDR;
  assign w_idx      = w_offset[DEPTH_LOG2+1:2];
  assign w_aligned  = (bus.fetch_addr[1:0] == 2'b00);
  assign w_in_range = ({1'b0, w_offset} < (33'd4 << DEPTH_LOG2));
  assign w_ok       = w_aligned && w_in_range;
  assign w_act      = (r_state == READY) && bus.ena;
  assign w_wr       = w_act && bus.we && w_ok;

  // Storage has no reset; the CLEAR sweep provides the known-zero contents.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR)
      r_mem[r_clr_idx] <= 32'h0;
    else if (w_wr)
      r_mem[w_idx] <= bus.wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= CLEAR;
      r_clr_idx   <= '0;
      r_rdata     <= 32'h0;
      r_busy      <= 1'b1;
      r_err       <= 3'b000;
      r_wr_count  <= 16'h0;
      r_faddr     <= 32'h0;
      r_faddr_vld <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_rdata   <= 32'h0;
          r_clr_idx <= r_clr_idx + 1'b1;
          if (r_clr_idx == '1) begin
            r_state <= READY;
            r_busy  <= 1'b0;
          end
        end
        READY: begin
          if (bus.ena) begin
            // Read and write share fetch_addr, so write-first is just a bypass.
            if (!w_ok)
              r_rdata <= 32'h0;
            else if (bus.we)
              r_rdata <= bus.wdata;
            else
              r_rdata <= r_mem[w_idx];
            r_err <= r_err | {r_faddr_vld && (bus.addr != r_faddr),
                              !w_in_range, !w_aligned};
            if (w_wr && r_wr_count != 16'hFFFF)
              r_wr_count <= r_wr_count + 16'h1;
            r_faddr     <= bus.fetch_addr;
            r_faddr_vld <= 1'b1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.busy     = r_busy;
  assign bus.err      = r_err;
  assign bus.wr_count = r_wr_count;
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, word-count exponent (2^DEPTH_LOG2 32-bit words).
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of word 0.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port ena  input  1  core enable; 0 freezes read register, writes, counters.
REQ-006 The block SHALL have port fetch_addr  input  32  early byte address (core ID stage) for read and write.
REQ-007 The block SHALL have port addr  input  32  late byte address (core EXE stage) for consistency check.
REQ-008 The block SHALL have port wdata  input  32  write data.
REQ-009 The block SHALL have port we  input  1  write enable, qualified by ena.
REQ-010 The block SHALL have port rdata  output  32  registered read data.
REQ-011 The block SHALL have port busy  output  1  high while clearing memory.
REQ-012 The block SHALL have port err  output  3  sticky flags: [0] misaligned, [1] out of range, [2] addr mismatch.
REQ-013 The block SHALL have port wr_count  output  16  count of committed writes.

Function
REQ-014 Offset SHALL be fetch_addr - BASE_ADDR (32-bit, wrapping); in range iff offset < 4*2^DEPTH_LOG2; word index = offset[DEPTH_LOG2+1:2]; aligned iff fetch_addr[1:0]==0.
REQ-015 The FSM SHALL have two states, CLEAR and READY; reset forces CLEAR with clear index 0.
REQ-016 In CLEAR, each clock SHALL write 0 to word clear index and increment it, regardless of ena; after writing the last word, the FSM SHALL go to READY.
REQ-017 busy SHALL equal 1 exactly while in CLEAR; it deasserts 2^DEPTH_LOG2 rising edges after reset release.
REQ-018 In CLEAR, we SHALL be ignored (no write, no count, no err update) and rdata SHALL be 0.
REQ-019 In READY with ena=1, we=1, aligned and in range, mem[index] SHALL take wdata at the edge, and wr_count SHALL increment, saturating at 16'hFFFF.
REQ-020 In READY with ena=1, the read register SHALL load mem[index(fetch_addr)] at the edge; rdata shows it one cycle after fetch_addr is presented.
REQ-021 A simultaneous write and read of the same word SHALL be write-first: the read register loads wdata.
REQ-022 A misaligned or out-of-range access with ena=1 in READY SHALL load 0 into the read register, drop any write, and set err[0] and/or err[1].
REQ-023 The block SHALL register fetch_addr on every READY ena=1 edge; on the next READY ena=1 edge, if a registered address is valid and addr differs from it, err[2] SHALL set.
REQ-024 With ena=0, the read register, memory (except CLEAR writes), wr_count, registered address and err SHALL hold.
REQ-025 err bits SHALL clear only by reset.

Reset
REQ-026 Asserting reset (low) SHALL immediately force rdata=0, busy=1, err=0, wr_count=0, state CLEAR, clear index 0, and registered address invalid.
REQ-027 Reset asserted mid-CLEAR or mid-operation SHALL restart clearing from word 0 after release; memory contents are not guaranteed before CLEAR completes.

Verification (DEPTH_LOG2=4, BASE_ADDR=32'h0000_1000)
REQ-028 Release reset, ena=1 -> busy=1 for 16 edges, then 0; a read of 32'h1004 returns 0.
REQ-029 Write 32'hDEADBEEF to 32'h1008, then fetch_addr=32'h1008, addr tracking one cycle later -> rdata=32'hDEADBEEF one cycle after the read; wr_count=1; err=0.
REQ-030 Write 32'h12345678 to and read 32'h100C in the same cycle -> next-cycle rdata=32'h12345678.
REQ-031 Write to 32'h1002, then write to 32'h1040 -> err=3'b011, rdata=0 after each, wr_count unchanged, memory unchanged.
REQ-032 ena=0 for 3 cycles with we=1 and a changing fetch_addr -> rdata, wr_count, and memory unchanged; addr!=previous fetch_addr on the next ena=1 edge -> err[2]=1.
REQ-033 Assert reset 5 edges into CLEAR, then release -> busy stays 1 for a full 16 edges; err=0 and wr_count=0.
